demoscene_engine: RTL and testbench
===================================

# demoscene_engine

Parametrised next-generation demoscene core: one block holding VGA timing, a frame-synchronised configuration register bank, the background pattern generator and a square-wave audio source. Configuration arrives as byte writes over a valid/ready port, normally driven by the SPI slave. Writes land in shadow registers and take effect together at a frame boundary, so the picture never tears mid-frame. Colour depth and video timing are parameters.

## Interface
- COLOR_BITS, 2, bits per colour channel (1..8)
- H_DISPLAY / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48, horizontal timing in clocks
- V_DISPLAY / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33, vertical timing in lines
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_addr  in  3  register address
- cfg_data  in  8  write data
- vga_r, vga_g, vga_b  out  COLOR_BITS each  pixel colour
- hsync, vsync  out  1  active-low sync
- frame_start  out  1  one-cycle pulse on commit
- audio_out  out  1  square wave

## Operation
- Counters: h_count 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters. On wrap, v_count advances 0..V_TOTAL-1 and then wraps to 0. visible = h_count < H_DISPLAY && v_count < V_DISPLAY.
- Sync: hsync is low for h_count in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC). vsync follows the same rule on v_count.
- Shadow registers, written on a handshake. Only the low COLOR_BITS of the colour registers are kept.
  - addr0: [1:0] mode, [7] audio_en
  - addr1/2/3: colour R / G / B
  - addr4: scroll_step
  - addr5/6: audio period low / high byte
  - addr7: accepted and ignored
- Commit event: h_count==0 && v_count==V_DISPLAY.
  - All shadow registers are copied to the active set.
  - scroll_offset (8 bits) ← scroll_offset + active scroll_step, mod 256. The add uses the step being committed in this same cycle.
  - frame_start is pulsed.
- cfg_ready is 1 in every cycle except the commit cycle. A write presented in the commit cycle is not accepted; the master holds it, and it lands in the shadow set for the following frame.
- Pattern modes, all computed from the active registers. Let hs = h_count + scroll_offset (10 bits, wraps).
  - 0 solid: output = colour R/G/B.
  - 1 bars: b = hs[8:6]. Each channel is all-ones if its bit is set (b[0]→R, b[1]→G, b[2]→B), otherwise 0.
  - 2 checker: if hs[5] ^ v_count[5], output = colour; otherwise output = bitwise complement of colour.
  - 3 gradient: R = hs[7:8-COLOR_BITS], G = v_count[7:8-COLOR_BITS], B = scroll_offset[7:8-COLOR_BITS].
  - Not visible: all channels 0.
- Audio (active registers):
  - If audio_en is 0 or period is 0: the divider is held at 0 and audio_out is 0.
  - Otherwise the divider counts 0..period. At period it returns to 0 and audio_out toggles. Output frequency = clk / (2·(period+1)).
  - A period change at commit takes effect on the next divider compare. If the divider already exceeds the new period, it restarts at 0 without toggling.

## Timing
- Reset values:
  - counters 0; scroll_offset 0
  - all shadow and active registers 0
  - vga_r/g/b 0; hsync 1; vsync 1; frame_start 0; audio_out 0; cfg_ready 1
- Pipeline: colour, hsync and vsync outputs are registered one clock after the counter state that produced them, so all are mutually aligned.
- frame_start is also registered and appears in the same output cycle as the commit position.
- Shadow write to visible effect: the next commit, then one clock of output latency.
- Reset asserted mid-frame:
  - all state returns to reset values on the next edge
  - any in-flight write is dropped
  - the first frame after release starts at h=v=0
- Simultaneous write and commit: not possible, because cfg_ready=0 during commit.
- Two writes to the same address within one frame: the last write wins.

## Test plan
- Reset: hold reset 3 clocks with cfg_valid=1 → sync high, colours 0, no write accepted. After release, first hsync low edge 657 clocks later (default timing, includes the 1-cycle pipeline).
- Timing: run 2 frames → 525 lines × 800 clocks between frame_start pulses. hsync low 96 clocks, vsync low 2 lines.
- Shadowing: mode 0, write R=3 at line 100 → colour stays 0 for the rest of the frame. R=3 from line 0 of the next frame. Write attempted in the commit cycle is held off for one clock.
- Bars with scroll: mode 1, scroll_step=64 → pixel h=0 shows bar b=1 (R=3, G=0, B=0) in frame 1, and b=2 in frame 2. Blanking outputs are 0.
- Checker / gradient at COLOR_BITS=2: colour (1,2,0) → pixel (0,0) gives (2,1,3) and pixel (32,0) gives (1,2,0). Mode 3 at h=200, offset 0 gives R=3.
- Audio: audio_en=1, period=4 → toggle every 5 clocks. Setting period=0 forces audio_out low after the next commit.

Source files
------------

// File: rtl/demoscene_engine.sv
// Demoscene core: VGA timing, frame-synchronised config register bank,
// background pattern generator and square-wave audio in one clock domain.
module demoscene_engine #(
  parameter int COLOR_BITS = 2,
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start,
  output logic                  audio_out
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_COMMIT = VW'(V_DISPLAY);

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                 mode;
    logic                  audio_en;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
    logic [7:0]            scroll_step;
    logic [15:0]           period;
  } regs_t;

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          commit;
  regs_t         shadow_q;
  regs_t         active_q;
  logic [7:0]    scroll_offset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign commit    = (h_count == '0) && (v_count == V_COMMIT);
  assign cfg_ready = !commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        3'd0: begin
          shadow_q.mode     <= mode_e'(cfg_data[1:0]);
          shadow_q.audio_en <= cfg_data[7];
        end
        3'd1:    shadow_q.r            <= cfg_data[COLOR_BITS-1:0];
        3'd2:    shadow_q.g            <= cfg_data[COLOR_BITS-1:0];
        3'd3:    shadow_q.b            <= cfg_data[COLOR_BITS-1:0];
        3'd4:    shadow_q.scroll_step  <= cfg_data;
        3'd5:    shadow_q.period[7:0]  <= cfg_data;
        3'd6:    shadow_q.period[15:8] <= cfg_data;
        default: ;
      endcase
    end
  end

  // The scroll add uses the step being committed, not the outgoing one.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= '0;
      scroll_offset <= '0;
    end else if (commit) begin
      active_q      <= shadow_q;
      scroll_offset <= scroll_offset + shadow_q.scroll_step;
    end
  end

  logic [8:0]            hs;
  logic [7:0]            vc;
  logic                  visible;
  logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;
  logic                  hsync_d, vsync_d;

  assign hs      = 9'(h_count) + 9'(scroll_offset);
  assign vc      = 8'(v_count);
  assign visible = (32'(h_count) < H_DISPLAY) && (32'(v_count) < V_DISPLAY);
  assign hsync_d = !((32'(h_count) >= HS_START) && (32'(h_count) < HS_END));
  assign vsync_d = !((32'(v_count) >= VS_START) && (32'(v_count) < VS_END));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (visible) begin
      case (active_q.mode)
        MODE_SOLID: begin
          pix_r = active_q.r;
          pix_g = active_q.g;
          pix_b = active_q.b;
        end
        MODE_BARS: begin
          pix_r = {COLOR_BITS{hs[6]}};
          pix_g = {COLOR_BITS{hs[7]}};
          pix_b = {COLOR_BITS{hs[8]}};
        end
        MODE_CHECKER: begin
          if (hs[5] ^ vc[5]) begin
            pix_r = active_q.r;
            pix_g = active_q.g;
            pix_b = active_q.b;
          end else begin
            pix_r = ~active_q.r;
            pix_g = ~active_q.g;
            pix_b = ~active_q.b;
          end
        end
        MODE_GRADIENT: begin
          pix_r = hs[7 -: COLOR_BITS];
          pix_g = vc[7 -: COLOR_BITS];
          pix_b = scroll_offset[7 -: COLOR_BITS];
        end
        default: ;
      endcase
    end
  end

  // Single output stage keeps colour, syncs and frame_start aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pix_r;
      vga_g       <= pix_g;
      vga_b       <= pix_b;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      frame_start <= commit;
    end
  end

  logic [15:0] div_q;

  // A period shrunk below the running divider restarts it without a toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      audio_out <= 1'b0;
    end else if (!active_q.audio_en || active_q.period == '0) begin
      div_q     <= '0;
      audio_out <= 1'b0;
    end else if (div_q == active_q.period) begin
      div_q     <= '0;
      audio_out <= ~audio_out;
    end else if (div_q > active_q.period) begin
      div_q     <= '0;
    end else begin
      div_q     <= div_q + 1'b1;
    end
  end

  logic unused;
  assign unused = ^{hs, vc, active_q.scroll_step};

endmodule

// File: tb/tb_demoscene_engine.sv
// Self-checking bench for demoscene_engine with a compact video timing;
// pixel expectations go through a position-tagged scoreboard queue.
module tb_demoscene_engine;

  localparam int CB = 2;
  localparam int HD = 208, HF = 4, HS = 8, HB = 4;
  localparam int VD = 40,  VF = 2, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [2:0]    cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic          hsync, vsync, frame_start, audio_out;

  always #5 clk = ~clk;

  demoscene_engine #(
    .COLOR_BITS(CB),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .audio_out(audio_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference raster position: ctr_* is the counter state, out_* the position
  // whose pixel is currently on the registered outputs.
  int ctr_h = 0, ctr_v = 0, ctr_f = 0;
  int out_h = 0, out_v = 0, out_f = 0;
  bit out_valid = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      ctr_h <= 0; ctr_v <= 0; ctr_f <= 0;
      out_valid <= 1'b0;
    end else begin
      out_h <= ctr_h; out_v <= ctr_v; out_f <= ctr_f;
      out_valid <= 1'b1;
      if (ctr_h == HT - 1) begin
        ctr_h <= 0;
        if (ctr_v == VT - 1) begin
          ctr_v <= 0;
          ctr_f <= ctr_f + 1;
        end else begin
          ctr_v <= ctr_v + 1;
        end
      end else begin
        ctr_h <= ctr_h + 1;
      end
    end
  end

  typedef struct {
    int f, h, v;
    logic [CB-1:0] r, g, b;
  } pix_t;

  pix_t sb[$];

  function automatic int lin(int f, int h, int v);
    return (f * VT + v) * HT + h;
  endfunction

  always @(negedge clk) begin
    if (out_valid && sb.size() > 0) begin
      if (lin(out_f, out_h, out_v) == lin(sb[0].f, sb[0].h, sb[0].v)) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== {sb[0].r, sb[0].g, sb[0].b}) begin
          errors++;
          $display("FAIL pixel f%0d (%0d,%0d): got rgb=%0d,%0d,%0d expected %0d,%0d,%0d",
                   sb[0].f, sb[0].h, sb[0].v, vga_r, vga_g, vga_b, sb[0].r, sb[0].g, sb[0].b);
        end
        void'(sb.pop_front());
      end else if (lin(out_f, out_h, out_v) > lin(sb[0].f, sb[0].h, sb[0].v)) begin
        checks++;
        errors++;
        $display("FAIL pixel f%0d (%0d,%0d): position passed before it was compared",
                 sb[0].f, sb[0].h, sb[0].v);
        void'(sb.pop_front());
      end
    end
  end

  // Pulse and sync width recorders.
  int fs_cyc[$];
  int fs_run = 0, fs_len = 0;
  int hs_run = 0, hs_len = 0;
  int vs_run = 0, vs_len = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      if (frame_start) begin
        fs_cyc.push_back(cyc);
        fs_run++;
      end else if (fs_run > 0) begin
        fs_len = fs_run; fs_run = 0;
      end
      if (!hsync) hs_run++;
      else if (hs_run > 0) begin hs_len = hs_run; hs_run = 0; end
      if (!vsync) vs_run++;
      else if (vs_run > 0) begin vs_len = vs_run; vs_run = 0; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pix(int f, int h, int v, logic [CB-1:0] r, logic [CB-1:0] g,
                            logic [CB-1:0] b);
    pix_t e;
    e.f = f; e.h = h; e.v = v; e.r = r; e.g = g; e.b = b;
    sb.push_back(e);
  endtask

  task automatic wait_pos(int f, int v, int h);
    int n = 0;
    while (!(ctr_f == f && ctr_v == v && ctr_h == h) && n < 40000) begin
      tick();
      n++;
    end
    if (n >= 40000) begin
      checks++;
      errors++;
      $display("FAIL wait_pos f%0d (%0d,%0d): not reached, now f%0d (%0d,%0d)",
               f, h, v, ctr_f, ctr_h, ctr_v);
    end
  endtask

  task automatic write_cfg(logic [2:0] a, logic [7:0] d);
    int n = 0;
    bit done = 1'b0;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    while (!done && n < 8) begin
      done = cfg_ready;
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL write_cfg addr %0d: not accepted within %0d clocks", a, n);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    checks++;
    if ({hsync, vsync, frame_start, audio_out, cfg_ready} !== 5'b11001 ||
        {vga_r, vga_g, vga_b} !== '0) begin
      errors++;
      $display("FAIL %s: got hs=%b vs=%b fs=%b au=%b rdy=%b rgb=%0d,%0d,%0d expected 1,1,0,0,1 rgb 0",
               tag, hsync, vsync, frame_start, audio_out, cfg_ready, vga_r, vga_g, vga_b);
    end
  endtask

  task automatic count_to_hsync_low(string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (hsync !== 1'b0 && n < 2000);
    checks++;
    if (n != HD + HF + 1) begin
      errors++;
      $display("FAIL %s: first hsync low after %0d clocks, expected %0d", tag, n, HD + HF + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_valid = 1'b1; cfg_addr = 3'd3; cfg_data = 8'h03;
    repeat (3) begin
      tick();
      check_reset_outputs("reset_state");
    end
    reset = 1'b0;
    cfg_valid = 1'b0;
    count_to_hsync_low("reset_hsync_latency");
  endtask

  task automatic test_shadowing();
    wait_pos(0, 20, 10);
    write_cfg(3'd1, 8'h02);
    write_cfg(3'd1, 8'h03);
    expect_pix(0, 50, 25, 0, 0, 0);
    expect_pix(1, 0, 0, 3, 0, 0);
    expect_pix(1, 100, 10, 3, 0, 0);
    expect_pix(1, 5, VD - 1, 3, 0, 0);
    wait_pos(0, VD, 0);
    cfg_valid = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd64;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_ready: got %b expected 0", cfg_ready);
    end
    tick();
    checks++;
    if (cfg_ready !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL commit_next: got ready=%b frame_start=%b expected 1,1", cfg_ready, frame_start);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_bars();
    wait_pos(1, 5, 10);
    write_cfg(3'd0, 8'h01);
    expect_pix(2, 0, 0, 3, 0, 0);
    expect_pix(2, 100, 0, 0, 3, 0);
    expect_pix(2, 210, 0, 0, 0, 0);
    expect_pix(2, 0, 45, 0, 0, 0);
    expect_pix(3, 0, 0, 0, 3, 0);
    expect_pix(3, 100, 0, 3, 3, 0);
  endtask

  task automatic test_timing();
    wait_pos(2, 2, 10);
    checks++;
    if (fs_cyc.size() < 2) begin
      errors++;
      $display("FAIL frame_period: got %0d frame_start pulses expected at least 2", fs_cyc.size());
    end else if (fs_cyc[1] - fs_cyc[0] != HT * VT) begin
      errors++;
      $display("FAIL frame_period: got %0d clocks expected %0d", fs_cyc[1] - fs_cyc[0], HT * VT);
    end
    checks++;
    if (fs_len != 1) begin
      errors++;
      $display("FAIL frame_start_width: got %0d expected 1", fs_len);
    end
    checks++;
    if (hs_len != HS) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected %0d", hs_len, HS);
    end
    checks++;
    if (vs_len != VS * HT) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected %0d", vs_len, VS * HT);
    end
  endtask

  task automatic test_checker();
    wait_pos(3, 2, 10);
    write_cfg(3'd0, 8'h82);
    write_cfg(3'd1, 8'h01);
    write_cfg(3'd2, 8'h02);
    write_cfg(3'd3, 8'h00);
    write_cfg(3'd4, 8'd128);
    write_cfg(3'd5, 8'd4);
    write_cfg(3'd6, 8'd0);
    expect_pix(4, 0, 0, 2, 1, 3);
    expect_pix(4, 32, 0, 1, 2, 0);
    expect_pix(4, 0, 32, 1, 2, 0);
    expect_pix(4, 32, 32, 2, 1, 3);
  endtask

  task automatic test_audio();
    int t[$];
    int n = 0;
    logic prev;
    wait_pos(4, 1, 10);
    prev = audio_out;
    while (t.size() < 4 && n < 200) begin
      tick();
      n++;
      if (audio_out !== prev) begin
        t.push_back(n);
        prev = audio_out;
      end
    end
    if (t.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL audio_toggle: got %0d toggles in %0d clocks expected 4", t.size(), n);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (t[i] - t[i-1] != 5) begin
          errors++;
          $display("FAIL audio_toggle: interval %0d got %0d expected 5", i, t[i] - t[i-1]);
        end
      end
    end
  endtask

  task automatic test_gradient();
    bit bad = 1'b0;
    wait_pos(4, 3, 10);
    write_cfg(3'd0, 8'h83);
    write_cfg(3'd4, 8'd0);
    write_cfg(3'd5, 8'd0);
    expect_pix(5, 5, 0, 0, 0, 0);
    expect_pix(5, 100, 0, 1, 0, 0);
    expect_pix(5, 200, 0, 3, 0, 0);
    wait_pos(5, 1, 10);
    repeat (30) begin
      tick();
      if (audio_out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL audio_period_zero: got audio_out toggling expected constant 0");
    end
  endtask

  task automatic test_reset_midframe();
    wait_pos(5, 5, 10);
    reset = 1'b1;
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h03;
    tick();
    check_reset_outputs("midframe_reset_state");
    tick();
    reset = 1'b0;
    cfg_valid = 1'b0;
    count_to_hsync_low("midframe_hsync_latency");
    expect_pix(0, 100, 1, 0, 0, 0);
    wait_pos(0, 2, 10);
  endtask

  initial begin
    test_reset();
    test_shadowing();
    test_bars();
    test_timing();
    test_checker();
    test_audio();
    test_gradient();
    test_reset_midframe();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
